gpzda_transmitter: RTL and testbench
====================================

GPZDA_TRANSMITTER -- requirements
Module: gpzda_transmitter

Interface
REQ-001 Parameter B, 8, bits per byte.
REQ-002 Parameter Prefix, "$GPZDA" (6 bytes), sentence prefix including "$", no separator.
REQ-003 Parameter Separator, ",", field separator byte.
REQ-004 clock  input  1  single clock, 100 MHz / 10 ns; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request one sentence; sampled only while idle.
REQ-007 utc  input  9*B  "hhmmss.ss", leftmost char in the top byte.
REQ-008 day  input  2*B  "dd", same packing.
REQ-009 month  input  2*B  "mm", same packing.
REQ-010 year  input  4*B  "yyyy", same packing.
REQ-011 ready  input  1  downstream (UART TX) accepts the byte this cycle.
REQ-012 valid  output  1  data holds a sentence byte.
REQ-013 data  output  B  current byte.
REQ-014 busy  output  1  sentence in progress.
REQ-015 done  output  1  one-cycle pulse, sentence complete.

Function
REQ-016 The sentence SHALL be 38 bytes with this index map:
- 0-5 Prefix
- 6 Separator
- 7-15 utc
- 16 Separator
- 17-18 day
- 19 Separator
- 20-21 month
- 22 Separator
- 23-26 year
- 27 Separator
- 28-32 "00,00"
- 33 "*"
- 34-35 checksum
- 36 CR 0x0D
- 37 LF 0x0A
REQ-017 The FSM SHALL have three states:
- S_Idle: goes to S_Send on start.
- S_Send: goes to S_Done on acceptance of index 37.
- S_Done: goes to S_Idle unconditionally after one cycle.
REQ-018 On the start cycle in S_Idle, the block SHALL latch utc/day/month/year internally, clear the byte index to 0 and clear the checksum to 0x00; later input changes SHALL NOT affect the sentence.
REQ-019 start SHALL be ignored in S_Send and S_Done; no queuing.
REQ-020 valid SHALL be 1 exactly in S_Send, asserted the cycle after start (latency 1).
REQ-021 A byte SHALL transfer only on a cycle with valid & ready; the index then increments by 1.
REQ-022 data and valid SHALL stay stable while valid & !ready.
REQ-023 The checksum SHALL be the B-bit XOR of bytes at indices 1-32, accumulated on each transfer.
REQ-024 Index 34 SHALL be the upper nibble of the checksum and index 35 the lower nibble, each as uppercase ASCII hex (0-9 -> 0x30-0x39, A-F -> 0x41-0x46).
REQ-025 ready may be held high continuously; the block SHALL then emit one byte per cycle, 38 consecutive cycles.
REQ-026 busy SHALL be 1 in S_Send and S_Done, and 0 in S_Idle.
REQ-027 done SHALL be 1 only in S_Done, i.e. the cycle after the LF transfer.
REQ-028 A new start SHALL be accepted no earlier than the first S_Idle cycle after done.
REQ-029 Input fields SHALL NOT be checked for digit validity; bytes are sent verbatim.
REQ-030 data SHALL be 0 whenever valid is 0.

Reset
REQ-031 reset SHALL immediately force S_Idle, with valid=0, data=0, busy=0, done=0, index=0 and checksum=0.
REQ-032 reset mid-sentence SHALL abort the sentence with no further bytes.
REQ-033 After reset deassertion, the first start SHALL send a complete sentence from index 0.
REQ-034 Latched field registers need no reset value.

Verification
REQ-035 Nominal sentence:
- Stimulus: utc="201530.00", day="04", month="07", year="2002", start for 1 cycle, ready tied 1.
- Response: bytes "$GPZDA,201530.00,04,07,2002,00,00*60" then 0x0D 0x0A, on 38 consecutive cycles.
- Then done for 1 cycle, busy falling with it.
REQ-036 Backpressure: same stimulus with ready toggled in a pseudo-random pattern -> identical 38-byte stream, data stable during every stall, checksum bytes "6","0".
REQ-037 start ignored while busy: pulse start again at byte 10 with different fields -> first sentence unchanged; no second sentence follows.
REQ-038 Reset mid-sentence: assert reset during byte 20 -> valid=0 and busy=0 immediately; a subsequent start yields a full correct sentence.
REQ-039 Hex coverage: fields whose XOR gives 0xAF -> index 34 = 0x41 ("A"), index 35 = 0x46 ("F"); also cover a checksum of 0x0A -> "0A".
REQ-040 Back-to-back: start on the first idle cycle after done -> second sentence begins the next cycle with no lost or duplicated bytes.

Source files
------------

// File: rtl/gpzda_transmitter.sv
// NMEA $GPZDA sentence serializer: latches time/date fields on start and streams the
// 38-byte sentence with checksum and CR/LF over a valid/ready byte handshake.
module gpzda_transmitter #(
  parameter int unsigned      B         = 8,
  parameter logic [6*B-1:0]   Prefix    = "$GPZDA",
  parameter logic [B-1:0]     Separator = ","
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [9*B-1:0] utc_i,
  input  logic [2*B-1:0] day_i,
  input  logic [2*B-1:0] month_i,
  input  logic [4*B-1:0] year_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [B-1:0] data_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  localparam logic [5:0] LastIdx = 6'd37;

  state_e         state_q, state_d;
  logic [5:0]     idx_q, idx_d;
  logic [B-1:0]   csum_q, csum_d;
  logic [9*B-1:0] utc_q;
  logic [2*B-1:0] day_q, month_q;
  logic [4*B-1:0] year_q;
  logic [B-1:0]   cur_byte;
  logic           load;
  int             k;

  // 0x30 + n for digits, 0x37 + n maps 10..15 onto 'A'..'F'.
  function automatic logic [B-1:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return B'(8'h30) + B'(n);
    else           return B'(8'h37) + B'(n);
  endfunction

  assign load = (state_q == StIdle) && start_i;

  always_ff @(posedge clk_i) begin
    if (load) begin
      utc_q   <= utc_i;
      day_q   <= day_i;
      month_q <= month_i;
      year_q  <= year_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end

  // Byte selected by the current index; fields are packed leftmost char in the top byte.
  always_comb begin
    cur_byte = '0;
    k        = int'(idx_q);
    if (k <= 5)       cur_byte = Prefix[(5 - k)*B +: B];
    else if (k == 6)  cur_byte = Separator;
    else if (k <= 15) cur_byte = utc_q[(15 - k)*B +: B];
    else if (k == 16) cur_byte = Separator;
    else if (k <= 18) cur_byte = day_q[(18 - k)*B +: B];
    else if (k == 19) cur_byte = Separator;
    else if (k <= 21) cur_byte = month_q[(21 - k)*B +: B];
    else if (k == 22) cur_byte = Separator;
    else if (k <= 26) cur_byte = year_q[(26 - k)*B +: B];
    else if (k == 27) cur_byte = Separator;
    else if (k == 30) cur_byte = Separator;
    else if (k <= 32) cur_byte = B'(8'h30);
    else if (k == 33) cur_byte = B'(8'h2A);
    else if (k == 34) cur_byte = hex_char(csum_q[7:4]);
    else if (k == 35) cur_byte = hex_char(csum_q[3:0]);
    else if (k == 36) cur_byte = B'(8'h0D);
    else if (k == 37) cur_byte = B'(8'h0A);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StSend;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      StSend: begin
        if (ready_i) begin
          idx_d = idx_q + 6'd1;
          // The '$' lead-in and everything from '*' on are outside the checksum.
          if (idx_q >= 6'd1 && idx_q <= 6'd32) csum_d = csum_q ^ cur_byte;
          if (idx_q == LastIdx) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_o = (state_q == StSend);
    data_o  = valid_o ? cur_byte : '0;
    busy_o  = (state_q != StIdle);
    done_o  = (state_q == StDone);
  end

endmodule

// File: tb/tb_gpzda_transmitter.sv
// Self-checking bench for gpzda_transmitter: a reference model queues expected sentence
// bytes at start, and a negedge monitor pops and compares each accepted byte.
module tb_gpzda_transmitter;

  logic        clk, rst, start, ready;
  logic [71:0] utc;
  logic [15:0] day, month;
  logic [31:0] year;
  logic        valid, busy, done;
  logic [7:0]  data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx[38];
  int          rx_cnt = 0;
  bit          stall_pending = 0;
  logic [7:0]  stall_data;
  bit          bp_en = 0;

  gpzda_transmitter dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .utc_i   (utc),
    .day_i   (day),
    .month_i (month),
    .year_i  (year),
    .ready_i (ready),
    .valid_o (valid),
    .data_o  (data),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard monitor: compare accepted bytes, stall stability, and idle data.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (stall_pending) begin
          n_checks++;
          if (data !== stall_data) begin
            n_fail++;
            $display("FAIL stall_stable: data=%h required %h", data, stall_data);
          end
        end
        if (ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_byte: data=%h required no transfer", data);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (data !== e) begin
              n_fail++;
              $display("FAIL byte[%0d]: data=%h required %h", rx_cnt, data, e);
            end
          end
          rx[rx_cnt % 38] = data;
          rx_cnt++;
          stall_pending = 0;
        end else begin
          stall_pending = 1;
          stall_data    = data;
        end
      end else begin
        stall_pending = 0;
        n_checks++;
        if (data !== 8'h00) begin
          n_fail++;
          $display("FAIL idle_data: data=%h required 00", data);
        end
      end
    end else begin
      stall_pending = 0;
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic model(input logic [71:0] u, input logic [15:0] d, input logic [15:0] m,
                       input logic [31:0] y, input bit push, output logic [7:0] cs);
    logic [7:0] s[$];
    string p = "$GPZDA";
    string t = "00,00";
    for (int i = 0; i < 6; i++) s.push_back(p[i]);
    s.push_back(8'h2C);
    for (int i = 0; i < 9; i++) s.push_back(u[(8-i)*8 +: 8]);
    s.push_back(8'h2C);
    for (int i = 0; i < 2; i++) s.push_back(d[(1-i)*8 +: 8]);
    s.push_back(8'h2C);
    for (int i = 0; i < 2; i++) s.push_back(m[(1-i)*8 +: 8]);
    s.push_back(8'h2C);
    for (int i = 0; i < 4; i++) s.push_back(y[(3-i)*8 +: 8]);
    s.push_back(8'h2C);
    for (int i = 0; i < 5; i++) s.push_back(t[i]);
    cs = 8'h00;
    for (int i = 1; i < s.size(); i++) cs ^= s[i];
    s.push_back(8'h2A);
    s.push_back(hexc(cs[7:4]));
    s.push_back(hexc(cs[3:0]));
    s.push_back(8'h0D);
    s.push_back(8'h0A);
    if (push) foreach (s[i]) exp_q.push_back(s[i]);
  endtask

  // Drives a one-cycle start; scrambles the fields afterwards so late changes are visible.
  task automatic do_start(input logic [71:0] u, input logic [15:0] d, input logic [15:0] m,
                          input logic [31:0] y, input bit push);
    logic [7:0] cs;
    model(u, d, m, y, push, cs);
    @(posedge clk);
    #1;
    start = 1'b1; utc = u; day = d; month = m; year = y;
    @(posedge clk);
    #1;
    start = 1'b0; utc = ~u; day = ~d; month = ~m; year = ~y;
  endtask

  task automatic wait_done(input int bound, output int cyc, output bit ok);
    cyc = 0;
    ok  = 0;
    while (cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int n, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rx_cnt >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    utc = '0; day = '0; month = '0; year = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 4;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: %b required 0", valid); end
    if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: %h required 00", data); end
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: %b required 0", busy); end
    if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: %b required 0", done); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_nominal;
    int cyc;
    bit ok;
    ready  = 1'b1;
    rx_cnt = 0;
    do_start("201530.00", "04", "07", "2002", 1);
    wait_done(200, cyc, ok);
    n_checks += 6;
    if (!ok) begin n_fail++; $display("FAIL nominal_done_timeout: done never seen"); end
    if (cyc !== 39) begin n_fail++; $display("FAIL nominal_latency: done at %0d required 39", cyc); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL nominal_busy_at_done: %b required 1", busy); end
    if (rx[34] !== 8'h36 || rx[35] !== 8'h30) begin
      n_fail++; $display("FAIL nominal_checksum: %h%h required 3630", rx[34], rx[35]);
    end
    if (rx_cnt !== 38) begin n_fail++; $display("FAIL nominal_count: %0d required 38", rx_cnt); end
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL nominal_leftover: %0d required 0", exp_q.size()); end
    @(negedge clk);
    n_checks += 2;
    if (done !== 1'b0) begin n_fail++; $display("FAIL nominal_done_pulse: %b required 0", done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL nominal_busy_fall: %b required 0", busy); end
  endtask

  task automatic test_backpressure;
    int cyc;
    bit ok;
    rx_cnt = 0;
    ready  = 1'b0;
    bp_en  = 1;
    do_start("201530.00", "04", "07", "2002", 1);
    wait_done(2000, cyc, ok);
    bp_en = 0;
    #2;
    ready = 1'b1;
    n_checks += 4;
    if (!ok) begin n_fail++; $display("FAIL bp_done_timeout: done never seen"); end
    if (rx_cnt !== 38) begin n_fail++; $display("FAIL bp_count: %0d required 38", rx_cnt); end
    if (rx[34] !== 8'h36 || rx[35] !== 8'h30) begin
      n_fail++; $display("FAIL bp_checksum: %h%h required 3630", rx[34], rx[35]);
    end
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL bp_leftover: %0d required 0", exp_q.size()); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_start_ignored;
    int cyc;
    bit ok;
    ready  = 1'b1;
    rx_cnt = 0;
    do_start("123456.78", "15", "11", "2024", 1);
    wait_rx(10, 100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ign_rx_timeout: rx=%0d required 10", rx_cnt); end
    do_start("999999.99", "31", "12", "1999", 0);
    wait_done(200, cyc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ign_done_timeout: done never seen"); end
    repeat (50) @(negedge clk);
    n_checks += 3;
    if (rx_cnt !== 38) begin n_fail++; $display("FAIL ign_count: %0d required 38", rx_cnt); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy: %b required 0", busy); end
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ign_leftover: %0d required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit ok;
    ready  = 1'b1;
    rx_cnt = 0;
    do_start("000000.00", "01", "01", "2000", 1);
    wait_rx(20, 100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_rx_timeout: rx=%0d required 20", rx_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks += 3;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: %b required 0", valid); end
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy: %b required 0", busy); end
    if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: %h required 00", data); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    rx_cnt = 0;
    do_start("235959.99", "28", "02", "2023", 1);
    wait_done(200, cyc, ok);
    n_checks += 3;
    if (!ok) begin n_fail++; $display("FAIL rstmid_done_timeout: done never seen"); end
    if (rx_cnt !== 38) begin n_fail++; $display("FAIL rstmid_count: %0d required 38", rx_cnt); end
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_leftover: %0d required 0", exp_q.size()); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_hex;
    logic [7:0]  tgt[2];
    logic [15:0] req[2];
    logic [31:0] y;
    logic [7:0]  cs;
    int cyc;
    bit ok;
    tgt[0] = 8'hAF; req[0] = 16'h4146;
    tgt[1] = 8'h0A; req[1] = 16'h3041;
    ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      y = {"201", 8'h00};
      model("101010.10", "09", "03", y, 0, cs);
      y[7:0] = cs ^ tgt[t];
      rx_cnt = 0;
      do_start("101010.10", "09", "03", y, 1);
      wait_done(200, cyc, ok);
      n_checks += 2;
      if (!ok) begin n_fail++; $display("FAIL hex_done_timeout[%0d]: done never seen", t); end
      if ({rx[34], rx[35]} !== req[t]) begin
        n_fail++; $display("FAIL hex_chars[%0d]: %h%h required %h", t, rx[34], rx[35], req[t]);
      end
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit ok;
    logic [7:0] cs;
    ready  = 1'b1;
    rx_cnt = 0;
    do_start("080808.08", "05", "06", "2010", 1);
    wait_done(200, cyc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_done1_timeout: done never seen"); end
    model("171717.17", "20", "10", "2030", 1, cs);
    @(posedge clk);
    #1;
    start = 1'b1; utc = "171717.17"; day = "20"; month = "10"; year = "2030";
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_latency: %b required 1", valid); end
    wait_done(200, cyc, ok);
    n_checks += 4;
    if (!ok) begin n_fail++; $display("FAIL b2b_done2_timeout: done never seen"); end
    if (cyc !== 38) begin n_fail++; $display("FAIL b2b_latency: done at %0d required 38", cyc); end
    if (rx_cnt !== 76) begin n_fail++; $display("FAIL b2b_count: %0d required 76", rx_cnt); end
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover: %0d required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_hex();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
